// File: rtl/max2831_pkg.sv
// Shared constants and state encoding for the MAX2831 3-wire SPI write controller.
package max2831_pkg;

  localparam int WORD_W = 18;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] REG_R3 = 4'd3;
  localparam logic [ADDR_W-1:0] REG_R4 = 4'd4;

  // Half-period index: 0 = setup, 1..36 = bit low/high halves, 37 = CS hold.
  localparam int HC_W = 6;
  localparam logic [HC_W-1:0] HC_LAST      = HC_W'(2 * WORD_W + 1);
  localparam logic [HC_W-1:0] HC_SCLK_MAX  = HC_W'(2 * WORD_W - 1);
  localparam logic [HC_W-1:0] HC_SHIFT_MIN = HC_W'(2);
  localparam logic [HC_W-1:0] HC_SHIFT_MAX = HC_W'(2 * WORD_W - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/max2831_spi_shifter.sv
// Serialises one 18-bit word MSB first: SCLK idles low, SDATA moves on falling edges,
// CS_B framed by one setup and one hold half-period.
module max2831_spi_shifter
  import max2831_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              sclk_o,
  output logic              sdata_o,
  output logic              cs_n_o,
  output logic              hold_o,
  output logic              last_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic              busy_q, busy_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic              sclk_q, sclk_d;
  logic              sdata_q, sdata_d;
  logic              cs_n_q, cs_n_d;
  logic [WORD_W-2:0] sreg_q, sreg_d;
  logic              div_end;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign hold_o  = busy_q && (hc_q == HC_LAST);
  assign last_o  = hold_o && div_end;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
  assign cs_n_o  = cs_n_q;

  always_comb begin
    busy_d  = busy_q;
    div_d   = div_q;
    hc_d    = hc_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    cs_n_d  = cs_n_q;
    sreg_d  = sreg_q;
    if (start_i && !busy_q) begin
      busy_d  = 1'b1;
      div_d   = '0;
      hc_d    = '0;
      sclk_d  = 1'b0;
      cs_n_d  = 1'b0;
      sdata_d = word_i[WORD_W-1];
      sreg_d  = word_i[WORD_W-2:0];
    end else if (busy_q) begin
      if (!div_end) begin
        div_d = div_q + 1'b1;
      end else begin
        div_d = '0;
        if (hc_q == HC_LAST) begin
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
          sdata_d = 1'b0;
          sclk_d  = 1'b0;
        end else begin
          hc_d   = hc_q + 1'b1;
          // Odd index moves into a high half; even index (2..34) into the next bit's low half.
          sclk_d = hc_q[0] && (hc_q <= HC_SCLK_MAX);
          if (!hc_q[0] && (hc_q >= HC_SHIFT_MIN) && (hc_q <= HC_SHIFT_MAX)) begin
            sdata_d = sreg_q[WORD_W-2];
            sreg_d  = {sreg_q[WORD_W-3:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      div_q   <= '0;
      hc_q    <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sreg_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      div_q   <= div_d;
      hc_q    <= hc_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      cs_n_q  <= cs_n_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule

// File: rtl/max2831_spi_ctrl.sv
// AFC/host arbitration and handshakes in front of the MAX2831 SPI shifter;
// sole driver of the transceiver serial pins.
module max2831_spi_ctrl
  import max2831_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              freq_tx_req,
  input  logic [DATA_W-1:0] data_out,
  input  logic              MSB_LSB,
  output logic              freq_tx_grant,
  output logic              max2831_ready,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  output logic              spi_sclk,
  output logic              spi_sdata,
  output logic              spi_cs_n
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic              last_host_q, last_host_d;
  logic              win_afc_q, win_afc_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              pick_afc;
  logic              win_req;
  logic              start;
  logic [WORD_W-1:0] word;
  logic              sh_hold;
  logic              sh_last;

  // On a tie the requester not served last wins.
  assign pick_afc = freq_tx_req && (!host_req || last_host_q);
  assign win_req  = win_afc_q ? freq_tx_req : host_req;
  assign word     = pick_afc ? {data_out, (MSB_LSB ? REG_R4 : REG_R3)}
                             : {host_data, host_addr};

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ready_d     = ready_q;
    ack_d       = 1'b0;
    last_host_d = last_host_q;
    win_afc_d   = win_afc_q;
    gap_d       = gap_q;
    start       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (freq_tx_req || host_req) begin
          start       = 1'b1;
          state_d     = ST_LOAD;
          win_afc_d   = pick_afc;
          last_host_d = !pick_afc;
          grant_d     = pick_afc;
          ready_d     = 1'b0;
        end
      end
      ST_LOAD: state_d = ST_SHIFT;
      ST_SHIFT, ST_HOLD: begin
        if (sh_last) begin
          state_d = ST_GAP;
          gap_d   = '0;
          ack_d   = !win_afc_q;
        end else if (sh_hold) begin
          state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(CS_GAP - 1)) begin
          // A request already withdrawn releases with no extra wait cycle.
          if (!win_req) begin
            state_d = ST_IDLE;
            grant_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!win_req) begin
          state_d = ST_IDLE;
          grant_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      ready_q     <= 1'b1;
      ack_q       <= 1'b0;
      last_host_q <= 1'b1;
      win_afc_q   <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      last_host_q <= last_host_d;
      win_afc_q   <= win_afc_d;
      gap_q       <= gap_d;
    end
  end

  max2831_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .start_i(start),
    .word_i (word),
    .sclk_o (spi_sclk),
    .sdata_o(spi_sdata),
    .cs_n_o (spi_cs_n),
    .hold_o (sh_hold),
    .last_o (sh_last)
  );

  assign freq_tx_grant = grant_q;
  assign max2831_ready = ready_q;
  assign host_ack      = ack_q;

endmodule

// File: tb/tb_max2831_spi_ctrl.sv
// Scoreboard bench: expected words queued at request time, compared as the SPI monitor decodes frames.
module tb_max2831_spi_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int CS_GAP    = 4;
  localparam int CS_LOW    = 38 * CLK_DIV;
  localparam int READY_LAT = CS_LOW + CS_GAP;
  localparam int WAIT_LIM  = 500;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        freq_tx_req = 1'b0;
  logic [13:0] data_out = '0;
  logic        MSB_LSB = 1'b0;
  logic        freq_tx_grant;
  logic        max2831_ready;
  logic        host_req = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [13:0] host_data = '0;
  logic        host_ack;
  logic        spi_sclk;
  logic        spi_sdata;
  logic        spi_cs_n;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          words_done = 0;
  int          mon_bits = 0;
  logic [17:0] exp_q[$];

  max2831_spi_ctrl #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .freq_tx_req  (freq_tx_req),
    .data_out     (data_out),
    .MSB_LSB      (MSB_LSB),
    .freq_tx_grant(freq_tx_grant),
    .max2831_ready(max2831_ready),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_ack     (host_ack),
    .spi_sclk     (spi_sclk),
    .spi_sdata    (spi_sdata),
    .spi_cs_n     (spi_cs_n)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI monitor: decode each CS_B frame, check length, gap and word against the queue.
  initial begin
    logic [17:0] sh;
    logic        in_word, seen_word, sclk_prev;
    int          low_cyc, hi_cyc;
    in_word = 1'b0; seen_word = 1'b0; sclk_prev = 1'b0;
    sh = '0; low_cyc = 0; hi_cyc = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        in_word = 1'b0; seen_word = 1'b0; mon_bits = 0; hi_cyc = 0;
      end else if (!spi_cs_n) begin
        if (!in_word) begin
          if (seen_word) check_val("cs_gap_min", 32'(hi_cyc >= CS_GAP), 32'd1);
          in_word = 1'b1; mon_bits = 0; sh = '0; low_cyc = 0;
        end
        low_cyc++;
        if (spi_sclk && !sclk_prev) begin
          sh = {sh[16:0], spi_sdata};
          mon_bits++;
        end
      end else begin
        if (in_word) begin
          in_word = 1'b0; seen_word = 1'b1; hi_cyc = 0;
          words_done++;
          check_val("bit_count", 32'(mon_bits), 32'd18);
          check_val("cs_low_len", 32'(low_cyc), 32'(CS_LOW));
          if (exp_q.size() == 0) check_val("sb_unexpected_word", {14'd0, sh}, 32'hFFFF_FFFF);
          else check_val("sb_word", {14'd0, sh}, {14'd0, exp_q.pop_front()});
        end
        hi_cyc++;
      end
      sclk_prev = spi_sclk;
    end
  end

  task automatic afc_write(input logic msb, input logic [13:0] d, input bit scramble, output int lat);
    int t0;
    bit ok;
    lat = -1;
    @(negedge HCLK);
    MSB_LSB = msb; data_out = d; freq_tx_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIM; i++) begin
      @(negedge HCLK);
      if (freq_tx_grant && !max2831_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check_val("afc_grant_timeout", 32'd0, 32'd1);
      freq_tx_req = 1'b0;
      return;
    end
    t0 = cyc;
    @(negedge HCLK);
    freq_tx_req = 1'b0;
    if (scramble) begin data_out = ~d; MSB_LSB = ~msb; end
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIM; i++) begin
      if (max2831_ready) begin ok = 1'b1; break; end
      @(negedge HCLK);
    end
    if (!ok) check_val("afc_ready_timeout", 32'd0, 32'd1);
    else lat = cyc - t0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [13:0] d);
    bit ok, saw_grant;
    @(negedge HCLK);
    host_addr = a; host_data = d; host_req = 1'b1;
    ok = 1'b0; saw_grant = 1'b0;
    for (int i = 0; i < WAIT_LIM; i++) begin
      @(negedge HCLK);
      if (freq_tx_grant) saw_grant = 1'b1;
      if (host_ack) begin ok = 1'b1; break; end
    end
    host_req = 1'b0;
    if (!ok) begin
      check_val("host_ack_timeout", 32'd0, 32'd1);
      return;
    end
    check_val("host_no_grant", 32'(saw_grant), 32'd0);
    check_val("host_ack_cs_high", 32'(spi_cs_n), 32'd1);
    @(negedge HCLK);
    check_val("host_ack_single", 32'(host_ack), 32'd0);
  endtask

  initial begin
    int  lat;
    bit  ok, bad;
    #500_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int lat;
    bit ok, bad;

    repeat (3) @(negedge HCLK);
    check_val("rst_grant", 32'(freq_tx_grant), 32'd0);
    check_val("rst_ready", 32'(max2831_ready), 32'd1);
    check_val("rst_ack", 32'(host_ack), 32'd0);
    check_val("rst_sclk", 32'(spi_sclk), 32'd0);
    check_val("rst_sdata", 32'(spi_sdata), 32'd0);
    check_val("rst_cs_n", 32'(spi_cs_n), 32'd1);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // AFC to R4, ready latency from grant.
    exp_q.push_back(18'h10004);
    afc_write(1'b1, 14'h1000, 1'b0, lat);
    check_val("afc_r4_ready_lat", 32'(lat), 32'(READY_LAT));

    // Back-to-back AFC R4 then R3.
    exp_q.push_back(18'h10004);
    afc_write(1'b1, 14'h1000, 1'b0, lat);
    exp_q.push_back(18'h10783);
    afc_write(1'b0, 14'h1078, 1'b0, lat);
    check_val("afc_r3_ready_lat", 32'(lat), 32'(READY_LAT));

    // Host write.
    exp_q.push_back(18'h3FFF5);
    host_write(4'd5, 14'h3FFF);

    // AFC inputs changed mid-transfer must not affect the word.
    exp_q.push_back({14'h2C5A, 4'd4});
    afc_write(1'b1, 14'h2C5A, 1'b1, lat);
    MSB_LSB = 1'b0;

    // Two ties in a row after an AFC win: host, AFC, host, AFC.
    exp_q.push_back({14'h0ABC, 4'h7});
    exp_q.push_back({14'h0123, 4'h4});
    fork
      host_write(4'h7, 14'h0ABC);
      afc_write(1'b1, 14'h0123, 1'b0, lat);
    join
    check_val("tie1_afc_ready_lat", 32'(lat), 32'(READY_LAT));
    exp_q.push_back({14'h1555, 4'h9});
    exp_q.push_back({14'h2222, 4'h3});
    fork
      host_write(4'h9, 14'h1555);
      afc_write(1'b0, 14'h2222, 1'b0, lat);
    join

    // Reset in the middle of a frame.
    @(negedge HCLK);
    data_out = 14'h2AAA; MSB_LSB = 1'b1; freq_tx_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIM; i++) begin
      @(negedge HCLK);
      #1;
      if (mon_bits >= 9) begin ok = 1'b1; break; end
    end
    check_val("abort_reached_bit9", 32'(ok), 32'd1);
    HRESETn = 1'b0;
    freq_tx_req = 1'b0;
    #1;
    check_val("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check_val("abort_sclk", 32'(spi_sclk), 32'd0);
    check_val("abort_sdata", 32'(spi_sdata), 32'd0);
    check_val("abort_ready", 32'(max2831_ready), 32'd1);
    check_val("abort_grant", 32'(freq_tx_grant), 32'd0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge HCLK);
      if (freq_tx_grant || host_ack || !spi_cs_n || !max2831_ready) bad = 1'b1;
    end
    check_val("post_reset_quiet", 32'(bad), 32'd0);

    exp_q.push_back({14'h2AAA, 4'd4});
    afc_write(1'b1, 14'h2AAA, 1'b0, lat);
    check_val("post_reset_ready_lat", 32'(lat), 32'(READY_LAT));

    repeat (20) @(negedge HCLK);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    check_val("words_seen", 32'(words_done), 32'd10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/max2831_spi_ctrl.md
# max2831_spi_ctrl

Responder end of the AFC frequency-write handshake. Arbitrates between the auto-frequency-control requester (`freq_tx_req`/`freq_tx_grant`/`max2831_ready`) and a host register-write port, then serialises the selected 18-bit word (14 data + 4 address bits) onto the MAX2831 3-wire SPI bus. Sits between the AHB/AFC logic and the transceiver pins; it is the only driver of the MAX2831 serial interface.

## Interface
- `CLK_DIV`, 2: HCLK cycles per SCLK half-period (≥1).
- `CS_GAP`, 4: minimum HCLK cycles CS_B stays high between words (≥1).
- `HCLK` in 1: system clock.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `freq_tx_req` in 1: AFC requests a write; level, held until grant seen.
- `data_out` in 14: AFC data word (named as driven by AFC).
- `MSB_LSB` in 1: 1 → AFC word targets R4 (addr 4'd4); 0 → R3 (addr 4'd3).
- `freq_tx_grant` out 1: AFC owns the controller.
- `max2831_ready` out 1: controller idle, able to accept a request.
- `host_req` in 1: host write request; level, held with addr/data until `host_ack`.
- `host_addr` in 4: host register address.
- `host_data` in 14: host register data.
- `host_ack` out 1: one-cycle pulse, host word fully shifted and CS_B high.
- `spi_sclk` out 1: serial clock, idles low.
- `spi_sdata` out 1: serial data, MSB first.
- `spi_cs_n` out 1: chip select, active-low.

## Operation
- Reset values: `freq_tx_grant`=0, `max2831_ready`=1, `host_ack`=0, `spi_sclk`=0, `spi_sdata`=0, `spi_cs_n`=1; FSM in IDLE; last-winner flag = host.
- States: IDLE → LOAD → SHIFT → HOLD → GAP → RELEASE → IDLE.
- IDLE: `max2831_ready`=1. If any request sampled high, go LOAD. Both high: winner alternates (the requester not served last); otherwise the sole requester.
- LOAD (1 cycle): latch word = {data[13:0], addr[3:0]}; AFC addr from `MSB_LSB`. Assert `freq_tx_grant` if AFC won; drop `max2831_ready`; assert `spi_cs_n`=0. Setup phase of `CLK_DIV` cycles with SCLK low, bit 17 on SDATA.
- SHIFT: 18 bits, bit 17 first. Each bit: SCLK low `CLK_DIV` cycles, high `CLK_DIV` cycles; SDATA changes only while SCLK low (at falling edge), device samples on rising.
- HOLD: SCLK low, CS_B low for `CLK_DIV` cycles, then `spi_cs_n`=1, SDATA=0.
- GAP: CS_B high `CS_GAP` cycles. Host winner: `host_ack` pulses on first GAP cycle.
- RELEASE: wait until winning request is low; then drop `freq_tx_grant`, go IDLE (`max2831_ready`=1 next cycle). AFC normally drops its request one cycle after grant&~ready, so RELEASE is usually 0 wait cycles.
- Inputs are not re-sampled after LOAD; changes to data/addr mid-transfer have no effect.
- Request arriving while busy waits; no request is dropped.

## Timing
- Request sampled at edge N → LOAD/grant/ready=0/cs_n=0 visible after N+1.
- CS_B low duration = CLK_DIV + 36·CLK_DIV + CLK_DIV = 38·CLK_DIV cycles (76 at default).
- Earliest `max2831_ready` re-assertion: N+1+38·CLK_DIV+CS_GAP (+ RELEASE wait); 81 cycles after N at defaults.
- `freq_tx_grant` and `max2831_ready`=0 change in the same cycle, so AFC never sees grant&ready.
- Async reset mid-transfer: all outputs immediately to reset values, CS_B high aborts the partial word; no ack/grant emitted after reset release.

## Structure
- Package `max2831_pkg`: `WORD_W`=18, `DATA_W`=14, `ADDR_W`=4, `REG_R3`=4'd3, `REG_R4`=4'd4, FSM state enum.
- Sub-module `max2831_spi_shifter`: clock divider, bit counter, shift register, SCLK/SDATA/CS_B generation; top holds arbitration and handshakes.

## Test plan
- AFC `MSB_LSB`=1, `data_out`=14'h1000 → shifted word 18'h10004, CS_B low 76 cycles, ready back after AFC drops req.
- AFC `MSB_LSB`=0, `data_out`=14'h1078 → word 18'h10783; two back-to-back AFC requests (R4 then R3) separated by ≥4 cycles CS_B high.
- Host addr 4'd5, data 14'h3FFF → word 18'h3FFF5, single `host_ack` pulse, `freq_tx_grant` stays 0.
- Host and AFC request same cycle twice in a row → host served first, AFC second, then next tie goes to host.
- Reset asserted at bit 9 of a transfer → CS_B=1, SCLK=0, ready=1, grant=0 immediately; after release, fresh AFC request produces full correct 18-bit word.
- `data_out` changed mid-SHIFT → shifted word equals value latched in LOAD.
